// File: rtl/rtc_bus_responder_pkg.sv
// Shared definitions for the RTC bus responder: FSM encoding, timekeeping
// register offsets, BCD wrap limits and packed-BCD helper functions.
package rtc_bus_responder_pkg;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Register-file offsets of the timekeeping registers
    localparam logic [3:0] OFF_SEC = 4'd1;
    localparam logic [3:0] OFF_MIN = 4'd2;
    localparam logic [3:0] OFF_HR  = 4'd3;

    // Packed-BCD wrap limits
    localparam logic [7:0] SEC_LIMIT = 8'h59;
    localparam logic [7:0] MIN_LIMIT = 8'h59;
    localparam logic [7:0] HR_LIMIT  = 8'h23;

    // True when both nibbles hold a decimal digit
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Packed-BCD increment of a valid value below 8'h99
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // One counting step: {carry, next}. Non-BCD clears without carry;
    // reaching the limit wraps to zero with a carry.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lim);
        if (!bcd_valid(v))
            return {1'b0, 8'h00};
        else if (v >= lim)
            return {1'b1, 8'h00};
        else
            return {1'b0, bcd_inc(v)};
    endfunction

endpackage

// File: rtl/rtc_bcd_timekeeper.sv
// Packed-BCD seconds/minutes/hours advance on a 1 Hz tick. Purely
// combinational: produces the next value of each register. A bus write to a
// register in the same cycle wins in the register file, so the carry out of
// that register is suppressed here.
module rtc_bcd_timekeeper
    import rtc_bus_responder_pkg::*;
(
    input  logic       tick,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hr,
    input  logic       wr_sec,
    input  logic       wr_min,
    input  logic       wr_hr,
    output logic [7:0] sec_nxt,
    output logic [7:0] min_nxt,
    output logic [7:0] hr_nxt
);

    logic [8:0] sec_s;
    logic [8:0] min_s;
    logic [7:0] hr_s;
    logic       sec_carry;
    logic       min_carry;

    // Counting chain: seconds every tick, minutes and hours on carry;
    // non-BCD contents of any register clear on every tick.
    always_comb begin
        sec_s     = bcd_step(sec, SEC_LIMIT);
        min_s     = bcd_step(min, MIN_LIMIT);
        hr_s      = (!bcd_valid(hr) || hr >= HR_LIMIT) ? 8'h00 : bcd_inc(hr);
        sec_carry = tick & sec_s[8] & ~wr_sec;
        min_carry = sec_carry & min_s[8] & ~wr_min;

        sec_nxt = sec;
        min_nxt = min;
        hr_nxt  = hr;
        if (tick && !wr_sec)
            sec_nxt = sec_s[7:0];
        if (!wr_min && ((tick && !bcd_valid(min)) || sec_carry))
            min_nxt = min_s[7:0];
        if (!wr_hr && ((tick && !bcd_valid(hr)) || min_carry))
            hr_nxt = hr_s;
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device-side responder for the multiplexed 8-bit RTC bus. Synchronizes the
// strobes and bus, latches the address phase, and services write and read
// data phases against a 16-byte register file.
// Optional feature: define RTC_RESP_TICK_EN to build the BCD timekeeper that
// advances seconds/minutes/hours (offsets 1/2/3) on each tick pulse.
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE = 8'h20,
    parameter int         DEPTH     = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    inout  wire  [7:0] dato,
    input  logic       tick,
    output logic       acc_wr,
    output logic       acc_rd,
    output logic       proto_err
);

    // Synchronizer stages (p0/p1) plus one history stage on wr for edges
    logic       a_d_p0, a_d_p1;
    logic       cs_p0, cs_p1;
    logic       rd_p0, rd_p1;
    logic       wr_p0, wr_p1, wr_p2;
    logic [7:0] dato_p0, dato_p1;

    logic [1:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] rdata_q, rdata_d;
    logic       conflict_q;

    logic       wr_rise, wr_fall, conflict;
    logic       wr_commit, rd_start, err;
    logic [8:0] off_w;
    logic       in_range;
    logic [3:0] idx;
    logic       wr_hit;

    logic [7:0] regs    [DEPTH];
    logic [7:0] reg_nxt [DEPTH];

    // Strobe synchronizer; strobes reset to their inactive (high) level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_d_p0 <= 1'b0;
            a_d_p1 <= 1'b0;
            cs_p0  <= 1'b1;
            cs_p1  <= 1'b1;
            rd_p0  <= 1'b1;
            rd_p1  <= 1'b1;
            wr_p0  <= 1'b1;
            wr_p1  <= 1'b1;
            wr_p2  <= 1'b1;
        end else begin
            a_d_p0 <= a_d;
            a_d_p1 <= a_d_p0;
            cs_p0  <= cs;
            cs_p1  <= cs_p0;
            rd_p0  <= rd;
            rd_p1  <= rd_p0;
            wr_p0  <= wr;
            wr_p1  <= wr_p0;
            wr_p2  <= wr_p1;
        end
    end

    // Bus data synchronizer, kept cycle-aligned with the strobes
    always_ff @(posedge clk) begin
        dato_p0 <= dato;
        dato_p1 <= dato_p0;
    end

    assign wr_rise  = wr_p1 & ~wr_p2;
    assign wr_fall  = ~wr_p1 & wr_p2;
    assign conflict = ~cs_p1 & ~rd_p1 & ~wr_p1;

    // Window decode; the 9-bit difference makes addresses below the base
    // land far outside the window instead of wrapping into it.
    assign off_w    = {1'b0, addr_q} - {1'b0, ADDR_BASE};
    assign in_range = (off_w < 9'(DEPTH));
    assign idx      = off_w[3:0];
    assign wr_hit   = wr_commit & in_range;

    // FSM next-state and access decode
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        wr_commit = 1'b0;
        rd_start  = 1'b0;
        err       = 1'b0;
        if (conflict) begin
            // rd and wr low together: no access; flag only on entry
            err     = ~conflict_q;
            state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_ADDR;
        end else begin
            case (state_q)
                ST_DRIVE: begin
                    if (wr_fall)
                        err = 1'b1;
                    if (rd_p1 || cs_p1)
                        state_d = ST_ADDR;
                end
                default: begin
                    if (wr_rise && !cs_p1) begin
                        if (!a_d_p1) begin
                            addr_d  = dato_p1;
                            state_d = ST_ADDR;
                        end else if (state_q == ST_ADDR) begin
                            wr_commit = 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (state_q == ST_ADDR && !rd_p1 && !cs_p1 && a_d_p1) begin
                        state_d  = ST_DRIVE;
                        rd_start = 1'b1;
                        rdata_d  = in_range ? regs[idx] : 8'h00;
                    end
                end
            endcase
        end
    end

    // FSM, address latch, captured read data and access pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 8'h00;
            rdata_q    <= 8'h00;
            conflict_q <= 1'b0;
            acc_wr     <= 1'b0;
            acc_rd     <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            conflict_q <= conflict;
            acc_wr     <= wr_commit;
            acc_rd     <= rd_start;
            proto_err  <= err;
        end
    end

    // Released combinationally from state, so reset frees the bus at once
    assign dato = (state_q == ST_DRIVE) ? rdata_q : 8'hzz;

`ifdef RTC_RESP_TICK_EN
    logic [7:0] sec_nxt, min_nxt, hr_nxt;

    rtc_bcd_timekeeper u_timekeeper (
        .tick    (tick),
        .sec     (regs[OFF_SEC]),
        .min     (regs[OFF_MIN]),
        .hr      (regs[OFF_HR]),
        .wr_sec  (wr_hit && idx == OFF_SEC),
        .wr_min  (wr_hit && idx == OFF_MIN),
        .wr_hr   (wr_hit && idx == OFF_HR),
        .sec_nxt (sec_nxt),
        .min_nxt (min_nxt),
        .hr_nxt  (hr_nxt)
    );

    // Register next values: hold, with the timekeeper driving offsets 1..3
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            reg_nxt[i] = regs[i];
        reg_nxt[OFF_SEC] = sec_nxt;
        reg_nxt[OFF_MIN] = min_nxt;
        reg_nxt[OFF_HR]  = hr_nxt;
    end
`else
    logic unused_tick;
    assign unused_tick = tick;

    // Register next values: hold until a bus write
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            reg_nxt[i] = regs[i];
    end
`endif

    // Register file; a bus write takes priority over any other update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit && idx == 4'(i))
                    regs[i] <= dato_p1;
                else
                    regs[i] <= reg_nxt[i];
            end
        end
    end

endmodule
